// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB widths, flag type and broadcast packet.
package cdb_arbiter_pkg;
  localparam int GPR_SIZE = 64;
  localparam int ROB_IDX_SIZE = 4;
  typedef logic [3:0] nzcv_t;
  typedef struct packed {
    logic [GPR_SIZE-1:0] value;
    logic [ROB_IDX_SIZE-1:0] tag;
    logic set_nzcv;
    nzcv_t nzcv;
  } cdb_pkt_t;
endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select, first request after ptr wins.
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        gnt[(int'(ptr) + k) % N_REQ] = 1'b1;
        idx = IDX_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-requester 1-entry slots, round-robin onto a registered CDB.
// CDB_STATS_EN adds saturating grant and conflict counters.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DATA_W = GPR_SIZE,
  parameter int TAG_W = ROB_IDX_SIZE,
  parameter int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_flush,
  input  logic [N_REQ-1:0]      in_req_valid,
  input  logic [N_REQ*DATA_W-1:0] in_req_value,
  input  logic [N_REQ*TAG_W-1:0] in_req_tag,
  input  logic [N_REQ-1:0]      in_req_set_nzcv,
  input  logic [N_REQ*4-1:0]    in_req_nzcv,
  output logic [N_REQ-1:0]      out_req_ready,
  input  logic                  in_cdb_stall,
  output logic                  out_cdb_valid,
  output logic [DATA_W-1:0]     out_cdb_value,
  output logic [TAG_W-1:0]      out_cdb_tag,
  output logic                  out_cdb_set_nzcv,
  output logic [3:0]            out_cdb_nzcv,
  output logic [SRC_W-1:0]      out_cdb_src
`ifdef CDB_STATS_EN
  ,
  output logic [N_REQ*32-1:0]   out_stat_grants,
  output logic [31:0]           out_stat_conflicts
`endif
);
  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [TAG_W-1:0] tag;
    logic set_nzcv;
    nzcv_t nzcv;
  } pkt_t;
  pkt_t [N_REQ-1:0] in_pkt;
  pkt_t [N_REQ-1:0] slot;
  pkt_t out_pkt;
  logic [N_REQ-1:0] full, pick, gnt, hs;
  logic [SRC_W-1:0] ptr, idx;
  logic free;
  always_comb begin
    in_pkt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      in_pkt[i].value = in_req_value[i*DATA_W +: DATA_W];
      in_pkt[i].tag = in_req_tag[i*TAG_W +: TAG_W];
      in_pkt[i].set_nzcv = in_req_set_nzcv[i];
      in_pkt[i].nzcv = in_req_nzcv[i*4 +: 4];
    end
  end
  assign free = !out_cdb_valid || !in_cdb_stall;
  assign pick = (free && !in_flush) ? full : '0;
  assign out_req_ready = in_flush ? '0 : (~full | gnt);
  assign hs = in_req_valid & out_req_ready;
  rr_picker #(.N_REQ(N_REQ), .IDX_W(SRC_W)) u_pick (
    .req(pick),
    .ptr(ptr),
    .gnt(gnt),
    .idx(idx)
  );
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      full <= '0;
      slot <= '0;
      ptr <= SRC_W'(N_REQ - 1);
      out_cdb_valid <= 1'b0;
      out_pkt <= '0;
      out_cdb_src <= '0;
    end else if (in_flush) begin
      full <= '0;
      out_cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (hs[i]) begin
          full[i] <= 1'b1;
          slot[i] <= in_pkt[i];
        end else if (gnt[i]) begin
          full[i] <= 1'b0;
        end
      end
      if (|gnt) begin
        out_cdb_valid <= 1'b1;
        out_pkt <= slot[idx];
        out_cdb_src <= idx;
        ptr <= idx;
      end else if (free) begin
        out_cdb_valid <= 1'b0;
      end
    end
  end
  assign out_cdb_value = out_pkt.value;
  assign out_cdb_tag = out_pkt.tag;
  assign out_cdb_set_nzcv = out_pkt.set_nzcv;
  assign out_cdb_nzcv = out_pkt.nzcv;
`ifdef CDB_STATS_EN
  logic [N_REQ-1:0][31:0] grant_cnt;
  logic [31:0] conf_cnt;
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      grant_cnt <= '0;
      conf_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (gnt[i] && grant_cnt[i] != '1) grant_cnt[i] <= grant_cnt[i] + 32'd1;
      if (free && !in_flush && $countones(full) > 1 && conf_cnt != '1) conf_cnt <= conf_cnt + 32'd1;
    end
  end
  assign out_stat_grants = grant_cnt;
  assign out_stat_conflicts = conf_cnt;
`endif
endmodule
